// File: rtl/ahb3lite_uart_tx_buffer.sv
// ---------------------------------------------------------------------------
// ahb3lite_uart_tx_buffer
//
// AHB3-Lite slave implementing a buffered UART transmit path. Byte writes to
// TXDATA are queued in a FIFO; a small transmit engine hands one character
// at a time to a valid/ready byte stream and then idles for TX_GAP cycles.
// A write that finds the FIFO full is held with wait states until a slot
// frees up. STATUS reports empty/full/tx_valid and the FIFO occupancy.
//
// Register map (4-byte granules relative to BASE):
//   BASE+0..3  TXDATA  write-only, character taken from the addressed lane
//   BASE+4..7  STATUS  read-only  {16'0, count[7:0], 5'0, tx_valid, full, empty}
//   anything else, or the wrong direction, answers with a two-cycle ERROR.
//
// Ports:
//   HCLK, HRESETn          bus clock, asynchronous active-low reset
//   HSEL, HTRANS, HADDR,   AHB address phase
//   HWRITE, HSIZE, HBURST  (HSIZE/HBURST are accepted but not used)
//   HWDATA / HRDATA        write / read data
//   HREADY                 bus-level ready (end of the current data phase)
//   HREADYOUT, HRESP       slave ready and response
//   tx_valid, tx_char      character stream towards the consumer
//   tx_ready               consumer accepts tx_char while tx_valid is high
// ---------------------------------------------------------------------------
module ahb3lite_uart_tx_buffer #(
  parameter int          HDATA_SIZE = 32,
  parameter int          HADDR_SIZE = 32,
  parameter logic [31:0] BASE       = 32'h8000_1080,
  parameter int          DEPTH      = 8,
  parameter int          TX_GAP     = 16
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [1:0]            HTRANS,
  input  logic [HADDR_SIZE-1:0] HADDR,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [HDATA_SIZE-1:0] HWDATA,
  output logic [HDATA_SIZE-1:0] HRDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic                  tx_valid,
  output logic [7:0]            tx_char,
  input  logic                  tx_ready
);

  localparam int LANE_W = $clog2(HDATA_SIZE / 8);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int GAP_W  = $clog2(TX_GAP + 1);

  localparam logic [HADDR_SIZE-1:0] BASE_A   = HADDR_SIZE'(BASE);
  localparam logic [CNT_W-1:0]      DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [GAP_W-1:0]      GAP_LOAD = GAP_W'(TX_GAP - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP
  } tx_state_t;

  // -------------------------------------------------------------------------
  // Address phase decode
  // -------------------------------------------------------------------------
  logic [HADDR_SIZE-1:0] w_offset;
  logic [HADDR_SIZE-3:0] w_word;
  logic                  w_accept;
  logic                  w_dec_tx;
  logic                  w_dec_st;

  assign w_offset = HADDR - BASE_A;
  assign w_word   = w_offset[HADDR_SIZE-1:2];
  assign w_accept = HSEL & HREADY & HTRANS[1];
  assign w_dec_tx = HWRITE & (w_word == '0);
  assign w_dec_st = ~HWRITE & (w_word == (HADDR_SIZE-2)'(1));

  // -------------------------------------------------------------------------
  // Data phase state
  // -------------------------------------------------------------------------
  logic              r_tx_pend;   // TXDATA write waiting to be pushed
  logic              r_st_pend;   // STATUS read data phase
  logic              r_err1;      // first ERROR cycle (HREADYOUT low)
  logic              r_err2;      // second ERROR cycle (HREADYOUT high)
  logic [LANE_W-1:0] r_lane;

  // FIFO
  logic [7:0]        r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic [7:0]        w_wchar;

  // Transmit engine
  tx_state_t         r_state;
  tx_state_t         w_next_state;
  logic [GAP_W-1:0]  r_gap;
  logic [7:0]        r_tx_char;
  logic [31:0]       w_status;

  assign w_full  = (r_count == DEPTH_C);
  assign w_empty = (r_count == '0);

  // Only registered state feeds HREADYOUT: the stall is released by the
  // count dropping below DEPTH, never by anything on HWDATA.
  assign HREADYOUT = ~r_err1 & ~(r_tx_pend & w_full);
  assign HRESP     = r_err1 | r_err2;

  assign w_wchar = HWDATA[{r_lane, 3'b000} +: 8];
  assign w_push  = r_tx_pend & ~w_full;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the values from before the clock edge, independent of order.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_tx_pend <= 1'b0;
      r_st_pend <= 1'b0;
      r_err1    <= 1'b0;
      r_err2    <= 1'b0;
      r_lane    <= '0;
    end else begin
      r_err2 <= r_err1;
      if (HREADY) begin
        r_tx_pend <= w_accept & w_dec_tx;
        r_st_pend <= w_accept & w_dec_st;
        r_err1    <= w_accept & ~w_dec_tx & ~w_dec_st;
      end else begin
        // HREADY is low during our first ERROR cycle; it lasts one cycle.
        r_err1 <= 1'b0;
      end
      if (w_accept) begin
        r_lane <= HADDR[LANE_W-1:0];
      end
    end
  end

  // NOTE: the FIFO storage has no reset; the pointers and count define which
  // entries are valid, so clearing the array would only add reset fan-out.
  always_ff @(posedge HCLK) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_wchar;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Transmit engine
  // -------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_next_state = ST_SEND;
        end
      end
      ST_SEND: begin
        if (tx_ready) w_next_state = ST_GAP;
      end
      ST_GAP: begin
        if (r_gap == '0) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state   <= ST_IDLE;
      r_gap     <= '0;
      r_tx_char <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_pop) begin
        r_tx_char <= r_mem[r_rptr];
      end
      if (r_state == ST_SEND && tx_ready) begin
        r_gap <= GAP_LOAD;
      end else if (r_state == ST_GAP && r_gap != '0) begin
        r_gap <= r_gap - GAP_W'(1);
      end
    end
  end

  assign tx_valid = (r_state == ST_SEND);
  assign tx_char  = r_tx_char;

  // -------------------------------------------------------------------------
  // STATUS read data
  // -------------------------------------------------------------------------
  assign w_status = {16'd0, 8'(r_count), 5'd0, tx_valid, w_full, w_empty};
  assign HRDATA   = r_st_pend ? {(HDATA_SIZE/32){w_status}} : '0;

  // Transfer size/burst and the sub-word offset bits carry no information
  // for this slave.
  logic w_unused;
  assign w_unused = ^{HSIZE, HBURST, w_offset[1:0]};

endmodule

// File: tb/tb_ahb3lite_uart_tx_buffer.sv
// ---------------------------------------------------------------------------
// tb_ahb3lite_uart_tx_buffer
//
// Directed bench for ahb3lite_uart_tx_buffer. The stimulus thread drives AHB
// transfers and pushes the expected bus response and expected characters
// into queues; a monitor on the falling edge pops and compares whenever a
// data phase completes or a character handshake happens. A second, 64-bit
// instance checks byte-lane selection and STATUS replication.
// ---------------------------------------------------------------------------
module tb_ahb3lite_uart_tx_buffer;

  localparam logic [31:0] BASE   = 32'h8000_1080;
  localparam int          DEPTH  = 8;
  localparam int          TX_GAP = 16;

  typedef struct {
    bit          is_err;
    bit          stall;
    bit          chk_rd;
    logic [31:0] rd;
  } resp_t;

  typedef struct {
    logic [7:0] ch;
    int         spacing;   // expected cycles since previous handshake, -1 = don't care
  } char_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 32-bit instance
  logic        hsel, hwrite, hreadyout, hresp, tx_valid, tx_ready;
  logic [1:0]  htrans;
  logic [2:0]  hsize, hburst;
  logic [31:0] haddr, hwdata, hrdata;
  logic [7:0]  tx_char;

  // 64-bit instance
  logic        b_hsel, b_hwrite, b_hreadyout, b_hresp, b_txv, b_txr;
  logic [1:0]  b_htrans;
  logic [31:0] b_haddr;
  logic [63:0] b_hwdata, b_hrdata;
  logic [7:0]  b_txc;

  ahb3lite_uart_tx_buffer #(
    .HDATA_SIZE(32), .HADDR_SIZE(32), .BASE(BASE), .DEPTH(DEPTH), .TX_GAP(TX_GAP)
  ) dut (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel), .HTRANS(htrans), .HADDR(haddr),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata),
    .HRDATA(hrdata), .HREADY(hreadyout), .HREADYOUT(hreadyout), .HRESP(hresp),
    .tx_valid(tx_valid), .tx_char(tx_char), .tx_ready(tx_ready)
  );

  ahb3lite_uart_tx_buffer #(
    .HDATA_SIZE(64), .HADDR_SIZE(32), .BASE(BASE), .DEPTH(DEPTH), .TX_GAP(TX_GAP)
  ) dut64 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(b_hsel), .HTRANS(b_htrans), .HADDR(b_haddr),
    .HWRITE(b_hwrite), .HSIZE(3'b000), .HBURST(3'b000), .HWDATA(b_hwdata),
    .HRDATA(b_hrdata), .HREADY(b_hreadyout), .HREADYOUT(b_hreadyout), .HRESP(b_hresp),
    .tx_valid(b_txv), .tx_char(b_txc), .tx_ready(b_txr)
  );

  resp_t q_resp[$];
  char_t q_char[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic finish_run();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  endtask

  function automatic resp_t mk(bit err, bit stall, bit chk, logic [31:0] rd);
    resp_t r;
    r.is_err = err;
    r.stall  = stall;
    r.chk_rd = chk;
    r.rd     = rd;
    return r;
  endfunction

  task automatic push_char(input logic [7:0] ch, input int spacing);
    char_t c;
    c.ch      = ch;
    c.spacing = spacing;
    q_char.push_back(c);
  endtask

  // Non-pipelined transfer: address phase, then idle bus during the data
  // phase until HREADYOUT is seen high. Called and returns at posedge+1.
  task automatic ahb_xfer(input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input resp_t exp);
    int n;
    q_resp.push_back(exp);
    hsel = 1'b1; htrans = 2'b10; haddr = addr; hwrite = wr;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = wdata;
    n = 0;
    forever begin
      @(negedge clk);
      if (hreadyout) break;
      n++;
      if (n > 2000) begin
        check("bus_timeout", 64'(n), 64'd0);
        finish_run();
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_drain(input int max_cyc);
    int n = 0;
    while (q_char.size() != 0) begin
      @(posedge clk);
      n++;
      if (n > max_cyc) begin
        check("drain_timeout", 64'(q_char.size()), 64'd0);
        q_char.delete();
        break;
      end
    end
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  bit    dp_active = 1'b0;
  int    waits = 0;
  bit    resp_in_wait = 1'b0;
  bit    prev_txv = 1'b0;
  int    last_hs = 0;
  resp_t mon_e;
  char_t mon_c;

  always @(negedge clk) begin
    if (!rst_n) begin
      dp_active = 1'b0;
      prev_txv  = 1'b0;
    end else begin
      if (dp_active) begin
        if (!hreadyout) begin
          waits++;
          resp_in_wait |= hresp;
        end else begin
          if (q_resp.size() == 0) begin
            check("unexpected_resp", 64'd1, 64'd0);
          end else begin
            mon_e = q_resp.pop_front();
            if (mon_e.is_err)
              check("err_resp", {waits, resp_in_wait, hresp}, {32'd1, 1'b1, 1'b1});
            else if (mon_e.stall)
              check("stall_release", {waits > 0, hresp, tx_valid & ~prev_txv}, 3'b101);
            else
              check("okay_0ws", {waits, resp_in_wait, hresp}, {32'd0, 1'b0, 1'b0});
            if (mon_e.chk_rd) check("status_rd", hrdata, mon_e.rd);
          end
          dp_active = 1'b0;
        end
      end
      if (hsel && hreadyout && htrans[1]) begin
        dp_active    = 1'b1;
        waits        = 0;
        resp_in_wait = 1'b0;
      end
      if (tx_valid && tx_ready) begin
        if (q_char.size() == 0) begin
          check("unexpected_char", 64'(tx_char), 64'hFFFF);
        end else begin
          mon_c = q_char.pop_front();
          check("tx_char", tx_char, mon_c.ch);
          if (mon_c.spacing >= 0) check("hs_spacing", 64'(cyc - last_hs), 64'(mon_c.spacing));
        end
        last_hs = cyc;
      end
      prev_txv = tx_valid;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    bit got;
    rst_n = 1'b0;
    hsel = 0; htrans = 0; haddr = 0; hwrite = 0; hsize = 0; hburst = 0; hwdata = 0;
    tx_ready = 0;
    b_hsel = 0; b_htrans = 0; b_haddr = 0; b_hwrite = 0; b_hwdata = 0; b_txr = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_hreadyout", hreadyout, 1'b1);
    check("rst_hresp", hresp, 1'b0);
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_tx_char", tx_char, 8'h00);
    check("rst_hrdata", hrdata, 32'h0);
    @(posedge clk); #1;
    ahb_xfer(1'b0, BASE + 4, 32'h0, mk(0, 0, 1, 32'h0000_0001));

    // 'H','i' then 'S' on lane 2, consumer always ready
    tx_ready = 1'b1;
    push_char(8'h48, -1);
    ahb_xfer(1'b1, BASE, 32'hA5A5_A548, mk(0, 0, 0, 0));
    push_char(8'h69, TX_GAP + 2);
    ahb_xfer(1'b1, BASE, 32'h5A5A_5A69, mk(0, 0, 0, 0));
    push_char(8'h53, TX_GAP + 2);
    ahb_xfer(1'b1, BASE + 2, 32'hEE53_DDCC, mk(0, 0, 0, 0));
    wait_drain(200);
    repeat (TX_GAP + 4) @(posedge clk);
    #1;

    // Fill: first char sits in tx_char, the next eight fill the FIFO
    tx_ready = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      push_char(8'(8'h30 + i), (i == 1) ? -1 : TX_GAP + 2);
      ahb_xfer(1'b1, BASE, {24'hFFFFFF, 8'(8'h30 + i)}, mk(0, 0, 0, 0));
    end
    ahb_xfer(1'b0, BASE + 4, 32'h0, mk(0, 0, 1, 32'h0000_0806));
    // Tenth write stalls until the cycle after the next pop
    push_char(8'h3A, TX_GAP + 2);
    fork
      ahb_xfer(1'b1, BASE, 32'h0000_003A, mk(0, 1, 0, 0));
      begin
        repeat (6) @(posedge clk);
        #1 tx_ready = 1'b1;
      end
    join
    wait_drain(400);
    repeat (TX_GAP + 4) @(posedge clk);
    #1;
    ahb_xfer(1'b0, BASE + 4, 32'h0, mk(0, 0, 1, 32'h0000_0001));

    // Error responses leave the FIFO untouched
    tx_ready = 1'b0;
    ahb_xfer(1'b1, BASE, 32'h61, mk(0, 0, 0, 0));
    ahb_xfer(1'b1, BASE, 32'h62, mk(0, 0, 0, 0));
    ahb_xfer(1'b0, BASE + 4, 32'h0, mk(0, 0, 1, 32'h0000_0104));
    ahb_xfer(1'b0, BASE,     32'h0, mk(1, 0, 0, 0));
    ahb_xfer(1'b1, BASE + 4, 32'h77, mk(1, 0, 0, 0));
    ahb_xfer(1'b0, BASE + 8, 32'h0, mk(1, 0, 0, 0));
    ahb_xfer(1'b1, BASE + 8, 32'h78, mk(1, 0, 0, 0));
    ahb_xfer(1'b0, BASE + 4, 32'h0, mk(0, 0, 1, 32'h0000_0104));

    // Fill to full, start a stalled write, then reset mid-stall
    for (int i = 0; i < 7; i++) ahb_xfer(1'b1, BASE, 32'h63 + i, mk(0, 0, 0, 0));
    hsel = 1'b1; htrans = 2'b10; haddr = BASE; hwrite = 1'b1;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = 32'h7A;
    repeat (3) @(negedge clk);
    check("stall_hold", hreadyout, 1'b0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_hreadyout", hreadyout, 1'b1);
    check("rst_async_tx_valid", tx_valid, 1'b0);
    check("rst_async_hresp", hresp, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ahb_xfer(1'b0, BASE + 4, 32'h0, mk(0, 0, 1, 32'h0000_0001));
    tx_ready = 1'b1;
    push_char(8'h5A, -1);
    ahb_xfer(1'b1, BASE, 32'h0000_005A, mk(0, 0, 0, 0));
    wait_drain(100);
    repeat (TX_GAP + 4) @(posedge clk);
    #1;

    // 64-bit bus: lane 3 selected, STATUS replicated on both halves
    b_txr = 1'b1;
    b_hsel = 1'b1; b_htrans = 2'b10; b_haddr = BASE + 3; b_hwrite = 1'b1;
    @(posedge clk); #1;
    b_hsel = 1'b0; b_htrans = 2'b00; b_hwrite = 1'b0; b_hwdata = 64'hFFFF_FFFF_41FF_FFFF;
    @(negedge clk);
    check("w64_0ws", {b_hreadyout, b_hresp}, 2'b10);
    @(posedge clk); #1;
    b_hwdata = '0;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (b_txv && b_txr) begin
        check("w64_char", b_txc, 8'h41);
        got = 1'b1;
        break;
      end
    end
    if (!got) check("w64_char_seen", 64'd0, 64'd1);
    @(posedge clk); #1;
    b_hsel = 1'b1; b_htrans = 2'b10; b_haddr = BASE + 4; b_hwrite = 1'b0;
    @(posedge clk); #1;
    b_hsel = 1'b0; b_htrans = 2'b00;
    @(negedge clk);
    check("status64", b_hrdata, 64'h0000_0001_0000_0001);
    @(posedge clk); #1;

    check("resp_queue_empty", 64'(q_resp.size()), 64'd0);
    finish_run();
  end

  initial begin
    #200000;
    check("watchdog", 64'd1, 64'd0);
    finish_run();
  end

endmodule
